hazard_stall_unit: RTL

// - Consumer-side partner of the EX-stage forwarding unit. It detects the hazards forwarding cannot cover and stalls IF/ID.
// - Covered hazards: load-use RAW; RAW and structural hazards on the multi-cycle MUL/DIV unit in EX. It also generates the IF/ID flush for a branch taken in ID.
// - Sits beside the IF/ID and ID/EX pipeline registers. Drives the PC write-enable, the IF/ID write-enable, the ID/EX bubble mux and the IF/ID flush.

---
 rtl/hazard_stall_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Detects the pipeline hazards that the EX-stage forwarding unit cannot cover
// and stalls IF/ID. The stall cases are load-use RAW, RAW on the multi-cycle
// MUL/DIV unit, and structural conflict on the MUL/DIV unit. The block also
// generates the IF/ID flush for a branch that is resolved taken in ID.
//
// State table
//    state | meaning
//    IDLE  | no MUL/DIV in flight; a MUL/DIV in ID may be accepted
//    BUSY  | MUL/DIV occupies EX; cnt counts down to its Done cycle
//
// Ports
//    clk_i           clock
//    rst_i           synchronous active-high reset
//    IFID_RegRs_i    Rs of the instruction in ID
//    IFID_RegRt_i    Rt of the instruction in ID
//    IFID_UseRt_i    the instruction in ID reads Rt
//    IDEX_MemRead_i  the instruction in EX is a load
//    IDEX_RegRt_i    destination register of the load in EX
//    ID_MdStart_i    the instruction in ID is a MUL/DIV
//    ID_MdRd_i       destination register of that MUL/DIV
//    Branch_Taken_i  the branch in ID is resolved taken
//    PC_Write_o      PC write-enable
//    IFID_Write_o    IF/ID write-enable
//    IDEX_Bubble_o   zero all ID/EX control fields
//    IFID_Flush_o    clear IF/ID to a NOP
//    MD_Busy_o       a MUL/DIV is in flight
//    MD_Rd_o         destination of the in-flight MUL/DIV, 0 when idle
//    MD_Done_o       one-cycle pulse: the MUL/DIV result is valid in EX
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
   parameter int MD_LAT     = 4,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] IFID_RegRs_i,
   input  logic [REG_ADDR_W-1:0] IFID_RegRt_i,
   input  logic                  IFID_UseRt_i,
   input  logic                  IDEX_MemRead_i,
   input  logic [REG_ADDR_W-1:0] IDEX_RegRt_i,
   input  logic                  ID_MdStart_i,
   input  logic [REG_ADDR_W-1:0] ID_MdRd_i,
   input  logic                  Branch_Taken_i,
   output logic                  PC_Write_o,
   output logic                  IFID_Write_o,
   output logic                  IDEX_Bubble_o,
   output logic                  IFID_Flush_o,
   output logic                  MD_Busy_o,
   output logic [REG_ADDR_W-1:0] MD_Rd_o,
   output logic                  MD_Done_o
);

   localparam int CNT_W = $clog2(MD_LAT + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [REG_ADDR_W-1:0] r_md_rd;

   logic w_busy;
   logic w_cnt_last;
   logic w_load_use;
   logic w_md_raw;
   logic w_md_struct;
   logic w_stall;
   logic w_stall_eff;

   // Register $0 is hard-wired zero, so it never creates a dependency.
   function automatic logic f_match(
      input logic [REG_ADDR_W-1:0] r,
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] rt,
      input logic                  use_rt
   );
      return (r != '0) && ((rs == r) || (use_rt && (rt == r)));
   endfunction

   assign w_busy      = (r_state == BUSY);
   assign w_cnt_last  = (r_cnt == CNT_W'(1));

   assign w_load_use  = IDEX_MemRead_i &&
                        f_match(IDEX_RegRt_i, IFID_RegRs_i, IFID_RegRt_i, IFID_UseRt_i);
   assign w_md_raw    = w_busy &&
                        f_match(r_md_rd, IFID_RegRs_i, IFID_RegRt_i, IFID_UseRt_i);
   // Held through the Done cycle: a second MUL/DIV is never overlapped.
   assign w_md_struct = w_busy && ID_MdStart_i;
   assign w_stall     = w_load_use | w_md_raw | w_md_struct;

   // Reset is synchronous, so the registered state may still be BUSY while
   // rst_i is high; the pipeline controls are forced benign for that cycle.
   assign w_stall_eff = w_stall && !rst_i;

   assign PC_Write_o    = !w_stall_eff;
   assign IFID_Write_o  = !w_stall_eff;
   assign IDEX_Bubble_o = w_stall_eff;
   // A stalled branch is re-evaluated once the stall clears; flush then.
   assign IFID_Flush_o  = Branch_Taken_i && !w_stall && !rst_i;

   assign MD_Busy_o = w_busy;
   assign MD_Rd_o   = r_md_rd;
   assign MD_Done_o = w_busy && w_cnt_last && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_md_rd <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // In IDLE the only possible stall is load-use; a MUL/DIV
               // sitting behind it is not accepted this cycle.
               if (ID_MdStart_i && !w_stall) begin
                  r_state <= BUSY;
                  r_cnt   <= CNT_W'(MD_LAT);
                  r_md_rd <= ID_MdRd_i;
               end
            end
            BUSY: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_cnt_last) begin
                  r_state <= IDLE;
                  r_md_rd <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_md_rd <= '0;
            end
         endcase
      end
   end

endmodule
